fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Sequential datapath and state register of the synchronous FIFO; the stage directly downstream of the next-state decoder. Each cycle it registers the decoder's `next_state`, executes the write or read that state implies (storage, pointers, count), and feeds `state` and `data_count` back to the decoder. It also drives the FIFO status and handshake outputs to the surrounding logic.

## Interface
- `DATA_W`, 32: data word width.
- `ADDR_W`, 3: pointer width; depth = 2^ADDR_W = 8.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous reset, active-high.
- `next_state`  in  3  state chosen by the next-state decoder.
- `din`  in  DATA_W  write data, sampled in the cycle `next_state` = WRITE.
- `state`  out  3  registered current state, fed back to the decoder.
- `data_count`  out  ADDR_W+1  number of stored words, 0..8, fed back to the decoder.
- `dout`  out  DATA_W  registered read data.
- `full`, `empty`  out  1  `data_count` = 8 and `data_count` = 0, combinational from the count.
- `wr_ack`, `wr_err`, `rd_ack`, `rd_err`  out  1  each is high while `state` = WRITE, WR_ERR, READ or RD_ERR respectively.

## Operation
- State encoding: INIT 000, WRITE 001, WR_ERR 010, NO_OP 011, READ 100, RD_ERR 101.
- Operations are keyed on `next_state`, so each one completes on the same edge that loads `state`. The decoder therefore always sees the post-operation `data_count`.
- Effective next state `ns_eff`:
  - WRITE with `data_count` = 8 becomes WR_ERR.
  - READ with `data_count` = 0 becomes RD_ERR.
  - Codes 110 and 111 become NO_OP.
  - Every other code passes through unchanged.
- On each edge, `state` <= `ns_eff`, then:
  - WRITE: mem[tail] <= `din`; tail <= tail+1; count <= count+1.
  - READ: `dout` <= mem[head]; head <= head+1; count <= count−1.
  - All other states: storage, pointers, count and `dout` hold.
- Pointers are ADDR_W bits and wrap 7→0 naturally; head and tail are internal.
- Count never leaves 0..8 because of the guards above.
- Only one operation happens per cycle; simultaneous read and write is resolved upstream by the decoder.
- Reset values: `state` = INIT, head = tail = 0, `data_count` = 0, `dout` = 0.
- Reset effect on outputs: `empty` = 1, `full` = 0, all acks and errors = 0.
- Storage contents are not reset. Stale data is never read, because reads only occur when `data_count` > 0.
- Reset asserted mid-operation discards any in-flight write or read, and all registers return to their reset values immediately.

## Timing
- Write latency: `din` presented while `next_state` = WRITE is stored at the next edge. `wr_ack` and the incremented `data_count` are visible in the following cycle.
- Read latency: `dout` updates on the edge where `state` becomes READ and is valid for the whole cycle `rd_ack` = 1. `dout` holds until the next read.
- Back-to-back operations are supported: sustained writes store one word per cycle and sustained reads return one word per cycle.
- Full and empty boundaries:
  - The ninth consecutive write from empty yields `wr_err` = 1 with `data_count` = 8 unchanged.
  - A read at count 0 yields `rd_err` = 1 with `dout` unchanged.
- Error flags persist for as long as `state` remains in the error state.
- No combinational path exists from `next_state` to any output. The only combinational outputs are `full` and `empty`, derived from the registered count.

## Structure
- Shared package `fifo_pkg` holds:
  - the six state encodings (the next-state decoder uses the same package);
  - `FIFO_FULL` = 4'b1000 and `FIFO_EMPTY` = 4'b0000;
  - default `DATA_W` and `ADDR_W`.
- Sub-module `fifo_regfile` is a 2^ADDR_W × DATA_W array with a synchronous write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr` → `rdata`). It has no reset.
- `fifo_ctrl` contains the state register, the `ns_eff` guard, the head/tail/count registers, the `dout` register and the status decode.

## Test plan
- Reset then idle: `reset` pulse with `next_state` = NO_OP → `state` = INIT then 011; `data_count` = 0; `empty` = 1; `dout` = 0.
- Fill: 8 cycles of WRITE with `din` = 0xA0..0xA7 → `data_count` 1..8; `full` = 1 after the eighth write. A ninth WRITE → `wr_err` = 1 and count stays 8.
- Drain: 8 cycles of READ after the fill → `dout` = 0xA0..0xA7 in order with `rd_ack` = 1 each cycle. The ninth READ → `rd_err` = 1, `dout` stays 0xA7 and `empty` = 1.
- Wrap-around: write 6, read 6, write 5, read 5 (values 1..11) → read order is preserved across pointer wrap 7→0 and `data_count` returns to 0.
- Guard and illegal codes: `next_state` = READ at count 0 → `state` = RD_ERR. `next_state` = 111 → `state` = NO_OP with no count change.
- Mid-operation reset: `reset` asserted during a WRITE burst at count 5 → immediately `data_count` = 0, `state` = INIT and `wr_ack` = 0. A subsequent READ → `rd_err` = 1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: state codes, status
// constants and default geometry. The next-state decoder imports this too.
package fifo_pkg;

    localparam int FIFO_DATA_W = 32;
    localparam int FIFO_ADDR_W = 3;

    typedef enum logic [2:0] {
        INIT   = 3'b000,
        WRITE  = 3'b001,
        WR_ERR = 3'b010,
        NO_OP  = 3'b011,
        READ   = 3'b100,
        RD_ERR = 3'b101
    } state_t;

    localparam logic [3:0] FIFO_FULL  = 4'b1000;
    localparam logic [3:0] FIFO_EMPTY = 4'b0000;

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
// Contents are never read before being written because reads need count > 0.
module fifo_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Write port: store one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO state register and datapath. Registers the decoder's next_state
// (after full/empty guarding) and performs the write or read implied by it
// on the same edge, so the decoder always sees the post-operation count.
//
//   state  | meaning
//   -------+------------------------------------------
//   INIT   | after reset, nothing done yet
//   WRITE  | a word was stored on the last edge
//   WR_ERR | write requested while full, dropped
//   NO_OP  | idle (also any unused code 110/111)
//   READ   | a word was popped into dout on the last edge
//   RD_ERR | read requested while empty, dout held
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        next_state,
    input  logic [DATA_W-1:0] din,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   data_count,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              wr_ack,
    output logic              wr_err,
    output logic              rd_ack,
    output logic              rd_err
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);

    // Guard the requested state against full/empty and fold unused codes to NO_OP
    always_comb begin
        state_d = NO_OP;
        case (next_state)
            INIT:    state_d = INIT;
            WRITE:   state_d = full ? WR_ERR : WRITE;
            WR_ERR:  state_d = WR_ERR;
            NO_OP:   state_d = NO_OP;
            READ:    state_d = empty ? RD_ERR : READ;
            RD_ERR:  state_d = RD_ERR;
            default: state_d = NO_OP;
        endcase
    end

    // Pointer, count and read-data updates for the guarded state
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dout_d  = dout_q;
        wr_en   = 1'b0;
        case (state_d)
            WRITE: begin
                wr_en   = 1'b1;
                tail_d  = tail_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W+1)'(1);
            end
            READ: begin
                dout_d  = rd_data;
                head_d  = head_q + ADDR_W'(1);
                count_d = count_q - (ADDR_W+1)'(1);
            end
            default: ;
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    fifo_regfile #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk   (clk),
        .we    (wr_en),
        .waddr (tail_q),
        .wdata (din),
        .raddr (head_q),
        .rdata (rd_data)
    );

    assign state      = state_q;
    assign data_count = count_q;
    assign dout       = dout_q;
    assign wr_ack     = (state_q == WRITE);
    assign wr_err     = (state_q == WR_ERR);
    assign rd_ack     = (state_q == READ);
    assign rd_err     = (state_q == RD_ERR);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: a queue-based FIFO model predicts each cycle's
// outputs, and a negedge monitor pops and compares them.
module tb_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_WR_ERR = 3'd2;
    localparam logic [2:0] S_NO_OP  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_RD_ERR = 3'd5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    next_state = 3'd3;
    logic [DW-1:0] din = '0;
    logic [2:0]    state;
    logic [AW:0]   data_count;
    logic [DW-1:0] dout;
    logic          full, empty, wr_ack, wr_err, rd_ack, rd_err;

    typedef struct {
        logic [2:0]    st;
        int unsigned   cnt;
        logic [DW-1:0] dout;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout = '0;
    int            n_cmp = 0;
    int            n_bad = 0;

    fifo_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .next_state (next_state),
        .din        (din),
        .state      (state),
        .data_count (data_count),
        .dout       (dout),
        .full       (full),
        .empty      (empty),
        .wr_ack     (wr_ack),
        .wr_err     (wr_err),
        .rd_ack     (rd_ack),
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Drive one cycle of stimulus and push the model's prediction for it
    task automatic step(input logic [2:0] ns, input logic [DW-1:0] d, input logic rst);
        exp_t       e;
        logic [2:0] eff;
        @(negedge clk);
        #1;
        reset      = rst;
        next_state = ns;
        din        = d;
        if (rst) begin
            model_q.delete();
            model_dout = '0;
            eff = S_INIT;
        end else begin
            eff = ns;
            if (ns == S_WRITE && model_q.size() == 8) eff = S_WR_ERR;
            else if (ns == S_READ && model_q.size() == 0) eff = S_RD_ERR;
            else if (ns > 3'd5) eff = S_NO_OP;
            if (eff == S_WRITE) model_q.push_back(d);
            if (eff == S_READ) model_dout = model_q.pop_front();
        end
        e.st   = eff;
        e.cnt  = model_q.size();
        e.dout = model_dout;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every output against the oldest prediction
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("state",      64'(state),      64'(mon_e.st));
            check("data_count", 64'(data_count), 64'(mon_e.cnt));
            check("dout",       64'(dout),       64'(mon_e.dout));
            check("full",       64'(full),       64'(mon_e.cnt == 8));
            check("empty",      64'(empty),      64'(mon_e.cnt == 0));
            check("wr_ack",     64'(wr_ack),     64'(mon_e.st == S_WRITE));
            check("wr_err",     64'(wr_err),     64'(mon_e.st == S_WR_ERR));
            check("rd_ack",     64'(rd_ack),     64'(mon_e.st == S_READ));
            check("rd_err",     64'(rd_err),     64'(mon_e.st == S_RD_ERR));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ns;
        int         r;

        // Reset then idle
        step(S_NO_OP, '0, 1'b1);
        step(S_NO_OP, '0, 1'b1);
        step(S_NO_OP, '0, 1'b0);

        // Fill, overflow twice (error persists)
        for (int i = 0; i < 8; i++) step(S_WRITE, DW'(32'hA0 + i), 1'b0);
        step(S_WRITE, 32'hDEAD, 1'b0);
        step(S_WRITE, 32'hBEEF, 1'b0);

        // Drain, underflow
        for (int i = 0; i < 8; i++) step(S_READ, '0, 1'b0);
        step(S_READ, '0, 1'b0);
        step(S_NO_OP, '0, 1'b0);

        // Wrap-around: write 6, read 6, write 5, read 5
        for (int i = 1; i <= 6; i++) step(S_WRITE, DW'(i), 1'b0);
        for (int i = 0; i < 6; i++) step(S_READ, '0, 1'b0);
        for (int i = 7; i <= 11; i++) step(S_WRITE, DW'(i), 1'b0);
        for (int i = 0; i < 5; i++) step(S_READ, '0, 1'b0);

        // Guard and illegal codes
        step(S_READ, '0, 1'b0);
        step(3'd7, '0, 1'b0);
        step(S_WRITE, 32'h55, 1'b0);
        step(3'd6, '0, 1'b0);
        step(S_READ, '0, 1'b0);

        // Mid-operation reset during a write burst at count 5
        for (int i = 0; i < 5; i++) step(S_WRITE, DW'(32'hC0 + i), 1'b0);
        step(S_WRITE, 32'hC5, 1'b1);
        #1;
        check("rst_state",  64'(state),      64'(S_INIT));
        check("rst_count",  64'(data_count), 64'd0);
        check("rst_wr_ack", 64'(wr_ack),     64'd0);
        step(S_READ, '0, 1'b0);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 42) ns = S_WRITE;
            else if (r < 82) ns = S_READ;
            else ns = 3'($urandom_range(0, 7));
            step(ns, DW'($urandom), ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end
        step(S_NO_OP, '0, 1'b0);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
